req_gnt_arbiter: RTL and testbench

//  N-channel round-robin request/grant arbiter with bounded grant hold.

---
 rtl/req_gnt_arbiter_pkg.sv | 23 ++
 rtl/req_gnt_arbiter_if.sv | 28 ++
 rtl/req_gnt_arbiter_rr_pick.sv | 41 ++++
 rtl/req_gnt_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_req_gnt_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/req_gnt_arbiter_pkg.sv
// Shared types and helpers for the round-robin request/grant arbiter.
package req_gnt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest grant vector onehot_to_idx accepts; callers zero-extend into it.
  localparam int MAX_CH = 32;

  function automatic int onehot_to_idx(input logic [MAX_CH-1:0] vec);
    int idx;
    idx = 0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (vec[k]) begin
        idx = k;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_gnt_arbiter_if.sv
// Request/grant bundle between N requesters (master) and the arbiter (slave).
interface req_gnt_arbiter_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0]         req;
  logic [N_CH-1:0]         gnt;
  logic                    gnt_valid;
  logic [$clog2(N_CH)-1:0] gnt_id;
  logic                    hold_expired;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  hold_expired
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output hold_expired
  );

endinterface

// File: rtl/req_gnt_arbiter_rr_pick.sv
// Rotating-priority encoder: first eligible (req & ~mask) channel at or after
// ptr, wrapping from N_CH-1 back to 0.
module rr_pick #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  input  logic [N_CH-1:0]         mask,
  output logic [$clog2(N_CH)-1:0] pick_idx,
  output logic                    pick_valid
);

  localparam int IW = $clog2(N_CH);

  logic [N_CH-1:0] eligible;
  logic [IW-1:0]   cand_idx [N_CH];

  assign eligible = req & ~mask;

  // cand_idx[k] is the channel examined at priority position k.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum = {1'b0, ptr} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(N_CH)) ? IW'(sum - (IW+1)'(N_CH))
                                                   : IW'(sum);
    end
  endgenerate

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (eligible[cand_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/req_gnt_arbiter.sv
// N-channel round-robin arbiter with registered one-hot grant and a bound on
// how long one channel may keep the resource while others are waiting.
module req_gnt_arbiter
  import req_gnt_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int MAX_HOLD  = 4,
  parameter bit ASSERT_EN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  req_gnt_arbiter_if.slave bus
);

  localparam int              IW        = $clog2(N_CH);
  localparam int              HCW       = $clog2(MAX_HOLD + 1);
  localparam int              BOUND     = (N_CH - 1) * MAX_HOLD + 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IW-1:0]   LAST_CH   = IW'(N_CH - 1);
  localparam logic [N_CH-1:0] ONE_HOT0  = N_CH'(1);

  arb_state_e      state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [HCW-1:0]  hold_cnt_reg;
  logic [N_CH-1:0] gnt_reg;
  logic            gnt_valid_reg;
  logic [IW-1:0]   gnt_id_reg;
  logic            hold_expired_reg;

  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [IW-1:0]   ptr_next;
  logic [N_CH-1:0] pick_onehot;
  logic            owner_req;
  logic            hold_last;

  // Masking with the current grant removes the owner from a forced rotation;
  // in IDLE the grant is zero so nothing is masked.
  rr_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .req        (bus.req),
    .ptr        (ptr_reg),
    .mask       (gnt_reg),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign ptr_next    = (pick_idx == LAST_CH) ? '0 : pick_idx + IW'(1);
  assign pick_onehot = ONE_HOT0 << pick_idx;
  assign owner_req   = bus.req[gnt_id_reg];
  assign hold_last   = (hold_cnt_reg == HOLD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      hold_cnt_reg     <= '0;
      gnt_reg          <= '0;
      gnt_valid_reg    <= 1'b0;
      gnt_id_reg       <= '0;
      hold_expired_reg <= 1'b0;
    end else begin
      hold_expired_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg     <= GRANT;
            gnt_reg       <= pick_onehot;
            gnt_valid_reg <= 1'b1;
            gnt_id_reg    <= pick_idx;
            ptr_reg       <= ptr_next;
            hold_cnt_reg  <= '0;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            if (pick_valid) begin
              gnt_reg      <= pick_onehot;
              gnt_id_reg   <= pick_idx;
              ptr_reg      <= ptr_next;
              hold_cnt_reg <= '0;
            end else begin
              state_reg     <= IDLE;
              gnt_reg       <= '0;
              gnt_valid_reg <= 1'b0;
              gnt_id_reg    <= '0;
              hold_cnt_reg  <= '0;
            end
          end else if (!hold_last) begin
            hold_cnt_reg <= hold_cnt_reg + HCW'(1);
          end else if (pick_valid) begin
            gnt_reg          <= pick_onehot;
            gnt_id_reg       <= pick_idx;
            ptr_reg          <= ptr_next;
            hold_cnt_reg     <= '0;
            hold_expired_reg <= 1'b1;
          end else begin
            // Sole requester: restart the hold window without a bubble.
            hold_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt          = gnt_reg;
  assign bus.gnt_valid    = gnt_valid_reg;
  assign bus.gnt_id       = gnt_id_reg;
  assign bus.hold_expired = hold_expired_reg;

  generate
    if (ASSERT_EN) begin : g_sva
      localparam int WCW = $clog2(BOUND + 1);
      localparam int RCW = $clog2(MAX_HOLD + 1);

      logic others_waiting;
      assign others_waiting = |(bus.req & ~gnt_reg);

      property p_onehot;
        @(posedge clk) disable iff (!reset) $onehot0(gnt_reg);
      endproperty
      a_onehot: assert property (p_onehot);

      property p_valid;
        @(posedge clk) disable iff (!reset) gnt_valid_reg == (|gnt_reg);
      endproperty
      a_valid: assert property (p_valid);

      property p_id;
        @(posedge clk) disable iff (!reset)
          gnt_valid_reg |-> (gnt_reg[gnt_id_reg] &&
                             onehot_to_idx(MAX_CH'(gnt_reg)) == int'(gnt_id_reg));
      endproperty
      a_id: assert property (p_id);

      property p_id_idle;
        @(posedge clk) disable iff (!reset) !gnt_valid_reg |-> (gnt_id_reg == '0);
      endproperty
      a_id_idle: assert property (p_id_idle);

      property p_hold_cnt;
        @(posedge clk) disable iff (!reset) hold_cnt_reg <= HOLD_LAST;
      endproperty
      a_hold_cnt: assert property (p_hold_cnt);

      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic           waiting;
        logic           holding;
        logic [WCW-1:0] wait_cnt_reg;
        logic [RCW-1:0] run_cnt_reg;

        assign waiting = bus.req[gi] && !gnt_reg[gi];
        assign holding = gnt_reg[gi] && others_waiting;

        // Saturating run lengths: cycles spent waiting, cycles held against others.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            wait_cnt_reg <= '0;
            run_cnt_reg  <= '0;
          end else begin
            if (!waiting) begin
              wait_cnt_reg <= '0;
            end else if (wait_cnt_reg != WCW'(BOUND)) begin
              wait_cnt_reg <= wait_cnt_reg + WCW'(1);
            end
            if (!holding) begin
              run_cnt_reg <= '0;
            end else if (run_cnt_reg != RCW'(MAX_HOLD)) begin
              run_cnt_reg <= run_cnt_reg + RCW'(1);
            end
          end
        end

        property p_gnt_had_req;
          @(posedge clk) disable iff (!reset) gnt_reg[gi] |-> $past(bus.req[gi]);
        endproperty
        a_gnt_had_req: assert property (p_gnt_had_req);

        property p_hold_limit;
          @(posedge clk) disable iff (!reset) holding |-> (run_cnt_reg < RCW'(MAX_HOLD));
        endproperty
        a_hold_limit: assert property (p_hold_limit);

        property p_fair;
          @(posedge clk) disable iff (!reset) waiting |-> (wait_cnt_reg < WCW'(BOUND));
        endproperty
        a_fair: assert property (p_fair);
      end
    end
  endgenerate

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Directed vector table plus reset corner sequences and a random soak for
// the 4-channel, hold-4 round-robin arbiter.
module tb_req_gnt_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       hexp;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[$];

  req_gnt_arbiter_if #(.N_CH(4)) bus ();

  req_gnt_arbiter #(
    .N_CH      (4),
    .MAX_HOLD  (4),
    .ASSERT_EN (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic [1:0] id,
                         input logic h);
    chk({name, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({name, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(g != 4'b0000));
    chk({name, ".gnt_id"}, 32'(bus.gnt_id), 32'(id));
    chk({name, ".hold_expired"}, 32'(bus.hold_expired), 32'(h));
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                     input logic h);
    vec_t v;
    v.req  = r;
    v.gnt  = g;
    v.id   = id;
    v.hexp = h;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [3:0] r, input logic [3:0] g,
                       input logic [1:0] id, input logic h);
    for (int k = 0; k < n; k++) add(r, g, id, h);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] r;
    int         wait_cnt [4];
    int         rst_left;

    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    bus.req  = 4'b0000;
    #2;
    reset    = 1'b0;
    bus.req  = 4'b1111;

    // Requests present while held in reset must never be granted.
    for (int c = 0; c < 5; c++) begin
      step();
      chk_out($sformatf("in_reset[%0d]", c), 4'b0000, 2'd0, 1'b0);
      $display("reset cycle %0d req=%b gnt=%b", c, bus.req, bus.gnt);
    end
    reset = 1'b1;

    // Full rotation after reset release; first entry is the release edge.
    add_n(4, 4'b1111, 4'b0001, 2'd0, 1'b0);
    add  (   4'b1111, 4'b0010, 2'd1, 1'b1);
    add_n(3, 4'b1111, 4'b0010, 2'd1, 1'b0);
    add  (   4'b1111, 4'b0100, 2'd2, 1'b1);
    add_n(3, 4'b1111, 4'b0100, 2'd2, 1'b0);
    add  (   4'b1111, 4'b1000, 2'd3, 1'b1);
    add_n(3, 4'b1111, 4'b1000, 2'd3, 1'b0);
    add  (   4'b0000, 4'b0000, 2'd0, 1'b0);
    // Single-cycle request: one grant cycle then idle.
    add  (   4'b0100, 4'b0100, 2'd2, 1'b0);
    add  (   4'b0000, 4'b0000, 2'd0, 1'b0);
    // Lone requester keeps the grant past MAX_HOLD without a gap.
    add_n(12, 4'b0010, 4'b0010, 2'd1, 1'b0);
    add  (   4'b0000, 4'b0000, 2'd0, 1'b0);
    // Wrapping pick from ptr=2, then releases hand over with no bubble.
    add  (   4'b0011, 4'b0001, 2'd0, 1'b0);
    add  (   4'b0010, 4'b0010, 2'd1, 1'b0);
    add  (   4'b1010, 4'b0010, 2'd1, 1'b0);
    add  (   4'b1000, 4'b1000, 2'd3, 1'b0);
    add  (   4'b0000, 4'b0000, 2'd0, 1'b0);
    // Forced rotation between channels 0 and 3 across the wrap point.
    add_n(4, 4'b1001, 4'b0001, 2'd0, 1'b0);
    add  (   4'b1001, 4'b1000, 2'd3, 1'b1);
    add_n(3, 4'b1001, 4'b1000, 2'd3, 1'b0);
    add  (   4'b1001, 4'b0001, 2'd0, 1'b1);
    add  (   4'b0000, 4'b0000, 2'd0, 1'b0);

    foreach (vecs[i]) begin
      bus.req = vecs[i].req;
      step();
      chk_out($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].id, vecs[i].hexp);
      $display("vec %0d req=%b gnt=%b id=%0d hexp=%b", i, vecs[i].req, bus.gnt,
               bus.gnt_id, bus.hold_expired);
    end

    // Asynchronous reset in the middle of channel 1's grant.
    reset = 1'b0;
    step();
    reset   = 1'b1;
    bus.req = 4'b1111;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) chk_out("mid_rst.first", 4'b0001, 2'd0, 1'b0);
      if (c == 5) chk_out("mid_rst.ch1_first", 4'b0010, 2'd1, 1'b1);
      if (c == 6) chk_out("mid_rst.ch1_second", 4'b0010, 2'd1, 1'b0);
      $display("mid_rst cycle %0d gnt=%b", c, bus.gnt);
    end
    #2;
    reset = 1'b0;
    #1;
    chk_out("mid_rst.async_clear", 4'b0000, 2'd0, 1'b0);
    $display("mid_rst async drop gnt=%b", bus.gnt);
    step();
    chk_out("mid_rst.held", 4'b0000, 2'd0, 1'b0);
    reset = 1'b1;
    step();
    chk_out("mid_rst.release", 4'b0001, 2'd0, 1'b0);
    $display("mid_rst release gnt=%b", bus.gnt);

    // Random soak with sticky requests and occasional reset pulses.
    r        = 4'b0000;
    rst_left = 0;
    for (int ch = 0; ch < 4; ch++) wait_cnt[ch] = 0;
    for (int s = 0; s < 10000; s++) begin
      if (rst_left == 0 && $urandom_range(0, 199) == 0) begin
        rst_left = $urandom_range(1, 3);
        $display("soak step %0d reset for %0d cycles", s, rst_left);
      end
      reset = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(0, 7) == 0) r[ch] = ~r[ch];
      end
      bus.req = r;
      step();
      if (!reset) begin
        chk("soak.rst_gnt", 32'(bus.gnt), 32'd0);
        for (int ch = 0; ch < 4; ch++) wait_cnt[ch] = 0;
      end else begin
        chk("soak.onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        chk("soak.valid", 32'(bus.gnt_valid), 32'(bus.gnt != 4'b0000));
        chk("soak.gnt_had_req", 32'(bus.gnt & ~r), 32'd0);
        if (bus.gnt_valid) chk("soak.id", 32'(bus.gnt[bus.gnt_id]), 32'd1);
        else chk("soak.id_idle", 32'(bus.gnt_id), 32'd0);
        for (int ch = 0; ch < 4; ch++) begin
          if (r[ch] && !bus.gnt[ch]) wait_cnt[ch]++;
          else wait_cnt[ch] = 0;
          chk($sformatf("soak.fair_ch%0d", ch), 32'(wait_cnt[ch] <= 12), 32'd1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
